// File: rtl/spi_pkg.sv
// Shared SPI definitions: transmitter state encoding, default timing constants,
// and the clock polarity / bit order that the receive path also assumes.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    SHIFT    = 2'd2
  } tx_state_t;

  localparam int   DEF_DIV_HALF      = 20;
  localparam int   DEF_PREAMBLE_BITS = 32;
  localparam logic SPI_CPOL          = 1'b0;
  localparam logic SPI_MSB_FIRST     = 1'b1;

endpackage

// File: rtl/spi_clk_gen.sv
// SPI_clk generator: half-period counter plus phase bit, with one-cycle strobes
// asserted in the cycle before SPI_clk rises or falls. Held at idle while en is low.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int DIV_HALF = DEF_DIV_HALF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic spi_clk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int HW = $clog2(DIV_HALF) + 1;

  logic [HW-1:0] hcnt;
  logic          phase;
  logic          half_end;

  assign half_end  = en && (hcnt == HW'(DIV_HALF - 1));
  assign rise_tick = half_end && !phase;
  assign fall_tick = half_end && phase;
  assign spi_clk   = phase ^ SPI_CPOL;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt  <= '0;
      phase <= 1'b0;
    end else if (!en) begin
      hcnt  <= '0;
      phase <= 1'b0;
    end else if (half_end) begin
      hcnt  <= '0;
      phase <= ~phase;
    end else begin
      hcnt <= hcnt + HW'(1);
    end
  end

endmodule

// File: rtl/spi_frame_tx.sv
// SPI frame transmitter: valid/ready words shifted out MSB-first, launched on SPI_clk falls.
// Define SPI_TX_CAL_PREAMBLE_EN to build in the calibration preamble (PREAMBLE state, cal_busy).
module spi_frame_tx
  import spi_pkg::*;
#(
  parameter int DWIDTH        = 8,
  parameter int DIV_HALF      = DEF_DIV_HALF,
  parameter int PREAMBLE_BITS = DEF_PREAMBLE_BITS
) (
  input  logic              CLK_40,
  input  logic              reset,
  input  logic [DWIDTH-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              cal_start,
  output logic              cal_busy,
  output logic              SPI_clk,
  output logic              SPI_mosi,
  output logic              SPI_cs_n,
  output logic              frame_done
);

  localparam int BW = $clog2(DWIDTH) + 1;

  tx_state_t         state, state_nxt;
  logic [DWIDTH-1:0] hold, shreg;
  logic              hold_valid;
  logic [BW-1:0]     bcnt;
  logic              clk_en, fall_tick, unused_rise_tick;
  logic              load, advance, finish;
  logic              cal_req, start_pre, pre_step;

  // Handshake: a word transfers on any posedge where tx_valid && tx_ready.
  // tx_ready depends only on hold_valid, never on tx_valid.
  assign tx_ready = !hold_valid;
  assign clk_en   = (state != IDLE);

  function automatic logic first_bit(input logic [DWIDTH-1:0] w);
    return SPI_MSB_FIRST ? w[DWIDTH-1] : w[0];
  endfunction

  function automatic logic [DWIDTH-1:0] drop_bit(input logic [DWIDTH-1:0] w);
    return SPI_MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  spi_clk_gen #(.DIV_HALF(DIV_HALF)) u_clk_gen (
    .clk       (CLK_40),
    .rst       (reset),
    .en        (clk_en),
    .spi_clk   (SPI_clk),
    .rise_tick (unused_rise_tick),
    .fall_tick (fall_tick)
  );

`ifdef SPI_TX_CAL_PREAMBLE_EN
  localparam int PW = $clog2(PREAMBLE_BITS) + 1;
  logic [PW-1:0] pcnt;
  logic          pre_last;

  assign cal_req  = cal_start;
  assign pre_last = (pcnt == '0);
  assign cal_busy = (state == PREAMBLE);

  always_ff @(posedge CLK_40 or posedge reset) begin
    if (reset) begin
      pcnt <= '0;
    end else if (start_pre) begin
      pcnt <= PW'(PREAMBLE_BITS - 1);
    end else if (pre_step) begin
      pcnt <= pcnt - PW'(1);
    end
  end
`else
  logic unused_cal;
  assign unused_cal = cal_start ^ PREAMBLE_BITS[0];
  assign cal_req    = 1'b0;
  assign cal_busy   = 1'b0;
`endif

  always_ff @(posedge CLK_40 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Word and preamble boundaries both fall on an SPI_clk falling edge, so a
  // queued word reloads on that same edge and the stream stays gap-free.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    finish    = 1'b0;
    start_pre = 1'b0;
    pre_step  = 1'b0;
    case (state)
      IDLE: begin
        if (cal_req) begin
          state_nxt = PREAMBLE;
          start_pre = 1'b1;
        end else if (hold_valid) begin
          state_nxt = SHIFT;
          load      = 1'b1;
        end
      end
      SHIFT: begin
        if (fall_tick) begin
          if (bcnt != '0) begin
            advance = 1'b1;
          end else if (hold_valid) begin
            load = 1'b1;
          end else begin
            state_nxt = IDLE;
            finish    = 1'b1;
          end
        end
      end
`ifdef SPI_TX_CAL_PREAMBLE_EN
      PREAMBLE: begin
        if (fall_tick) begin
          if (!pre_last) begin
            pre_step = 1'b1;
          end else if (hold_valid) begin
            state_nxt = SHIFT;
            load      = 1'b1;
          end else begin
            state_nxt = IDLE;
            finish    = 1'b1;
          end
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK_40 or posedge reset) begin
    if (reset) begin
      hold       <= '0;
      hold_valid <= 1'b0;
      shreg      <= '0;
      bcnt       <= '0;
      SPI_mosi   <= 1'b0;
      SPI_cs_n   <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= finish;
      if (load) begin
        hold_valid <= 1'b0;
      end else if (tx_valid && !hold_valid) begin
        hold       <= tx_data;
        hold_valid <= 1'b1;
      end
      if (load) begin
        shreg    <= drop_bit(hold);
        SPI_mosi <= first_bit(hold);
        bcnt     <= BW'(DWIDTH - 1);
        SPI_cs_n <= 1'b0;
      end else if (advance) begin
        shreg    <= drop_bit(shreg);
        SPI_mosi <= first_bit(shreg);
        bcnt     <= bcnt - BW'(1);
      end else if (finish) begin
        SPI_mosi <= 1'b0;
        SPI_cs_n <= 1'b1;
      end else if (start_pre) begin
        SPI_mosi <= 1'b1;
        SPI_cs_n <= 1'b0;
      end else if (pre_step) begin
        SPI_mosi <= ~SPI_mosi;
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_tx.sv
// Directed bench for spi_frame_tx (DIV_HALF=20, DWIDTH=8, PREAMBLE_BITS=4); the
// preamble scenarios run when SPI_TX_CAL_PREAMBLE_EN is defined, the macro-off scenario otherwise.
`timescale 1ns/1ps
module tb_spi_frame_tx;

  localparam int DW = 8;
  localparam int DH = 20;
  localparam int PB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] tx_data;
  logic          tx_valid, tx_ready, cal_start, cal_busy;
  logic          SPI_clk, SPI_mosi, SPI_cs_n, frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] cap_bits;
  int          cap_nrise, cap_nfall, cap_cs_at, cap_fd, cap_fd_at, cap_mosi_bad, cap_busy;
  int          cap_rise_cyc [0:63];
  logic        cap_fall_mosi [0:63];
  logic        ready_log [0:1199];

  spi_frame_tx #(.DWIDTH(DW), .DIV_HALF(DH), .PREAMBLE_BITS(PB)) dut (
    .CLK_40(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cal_start(cal_start), .cal_busy(cal_busy), .SPI_clk(SPI_clk), .SPI_mosi(SPI_mosi),
    .SPI_cs_n(SPI_cs_n), .frame_done(frame_done)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drivers
  task automatic send_word(input logic [DW-1:0] d);
    bit rs;
    tx_data  = d;
    tx_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      rs = tx_ready;
      tick();
      if (rs) break;
    end
    tx_valid = 1'b0;
  endtask

  task automatic wait_cs_low(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!SPI_cs_n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Records wire activity from the current sample (t=0) until SPI_cs_n goes high.
  task automatic capture(input int budget);
    logic prev_clk, prev_mosi;
    cap_bits = '0; cap_nrise = 0; cap_nfall = 0; cap_cs_at = -1; cap_fd = 0; cap_fd_at = -1;
    cap_mosi_bad = 0; cap_busy = 0; cap_rise_cyc[0] = -1;
    for (int i = 0; i < 1200; i++) ready_log[i] = 1'bx;
    prev_clk = SPI_clk; prev_mosi = SPI_mosi;
    ready_log[0] = tx_ready;
    if (cal_busy) cap_busy++;
    for (int t = 1; t <= budget; t++) begin
      tick();
      if (t < 1200) ready_log[t] = tx_ready;
      if (cal_busy) cap_busy++;
      if (frame_done) begin cap_fd++; cap_fd_at = t; end
      if (SPI_clk && !prev_clk && cap_nrise < 64) begin
        cap_rise_cyc[cap_nrise] = t;
        cap_bits = {cap_bits[30:0], SPI_mosi};
        cap_nrise++;
      end
      if (!SPI_clk && prev_clk && cap_nfall < 64) begin
        cap_fall_mosi[cap_nfall] = SPI_mosi;
        cap_nfall++;
      end
      if ((SPI_mosi !== prev_mosi) && !(prev_clk && !SPI_clk) && !SPI_cs_n) cap_mosi_bad++;
      prev_clk = SPI_clk; prev_mosi = SPI_mosi;
      if (SPI_cs_n) begin
        cap_cs_at = t;
        break;
      end
    end
  endtask

  function automatic int bad_spacing();
    int b = 0;
    for (int i = 1; i < cap_nrise; i++) if (cap_rise_cyc[i] - cap_rise_cyc[i-1] != 2*DH) b++;
    return b;
  endfunction

  // scenarios
  task automatic test_reset();
    #2;
    n_tests++; if ({SPI_clk, SPI_mosi, SPI_cs_n} !== 3'b001) begin n_fail++; $display("FAIL reset_lines: got clk,mosi,cs_n=%b expected 001", {SPI_clk, SPI_mosi, SPI_cs_n}); end
    n_tests++; if ({tx_ready, cal_busy, frame_done} !== 3'b100) begin n_fail++; $display("FAIL reset_status: got ready,busy,done=%b expected 100", {tx_ready, cal_busy, frame_done}); end
    repeat (3) tick();
    reset = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_single_word();
    send_word(8'hA5);
    n_tests++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready_at_E: got %b expected 0", tx_ready); end
    tick();
    n_tests++; if ({SPI_cs_n, SPI_mosi, SPI_clk} !== 3'b010) begin n_fail++; $display("FAIL single_E1_lines: got cs_n,mosi,clk=%b expected 010", {SPI_cs_n, SPI_mosi, SPI_clk}); end
    n_tests++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_E1: got %b expected 1", tx_ready); end
    capture(400);
    n_tests++; if (cap_bits !== 32'hA5 || cap_nrise != 8) begin n_fail++; $display("FAIL single_bits: got %h (%0d rises) expected a5 (8 rises)", cap_bits, cap_nrise); end
    n_tests++; if (cap_rise_cyc[0] != DH) begin n_fail++; $display("FAIL single_first_rise: got %0d expected %0d", cap_rise_cyc[0], DH); end
    n_tests++; if (bad_spacing() != 0) begin n_fail++; $display("FAIL single_spacing: got %0d bad gaps expected 0", bad_spacing()); end
    n_tests++; if (cap_cs_at != 320) begin n_fail++; $display("FAIL single_cs_rise: got %0d expected 320", cap_cs_at); end
    n_tests++; if (cap_fd != 1 || cap_fd_at != 320) begin n_fail++; $display("FAIL single_frame_done: got %0d pulses at %0d expected 1 at 320", cap_fd, cap_fd_at); end
    n_tests++; if (cap_mosi_bad != 0) begin n_fail++; $display("FAIL single_mosi_edges: got %0d bad changes expected 0", cap_mosi_bad); end
    tick();
    n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL single_done_width: got %b expected 0", frame_done); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    fork
      begin send_word(8'h3C); send_word(8'hC3); end
      begin wait_cs_low(10, ok); capture(800); end
    join
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_cs_fall: got %b expected 1", ok); end
    n_tests++; if (cap_bits !== 32'h3CC3 || cap_nrise != 16) begin n_fail++; $display("FAIL b2b_bits: got %h (%0d rises) expected 3cc3 (16 rises)", cap_bits, cap_nrise); end
    n_tests++; if (bad_spacing() != 0) begin n_fail++; $display("FAIL b2b_spacing: got %0d bad gaps expected 0", bad_spacing()); end
    n_tests++; if (cap_cs_at != 640) begin n_fail++; $display("FAIL b2b_cs_low_len: got %0d expected 640", cap_cs_at); end
    n_tests++; if (((cap_nfall >= 8) ? cap_fall_mosi[7] : 1'bx) !== 1'b1) begin n_fail++; $display("FAIL b2b_fall8_msb: got %b expected 1", (cap_nfall >= 8) ? cap_fall_mosi[7] : 1'bx); end
    n_tests++; if (cap_fd != 1 || cap_fd_at != 640) begin n_fail++; $display("FAIL b2b_frame_done: got %0d pulses at %0d expected 1 at 640", cap_fd, cap_fd_at); end
    n_tests++; if (cap_mosi_bad != 0) begin n_fail++; $display("FAIL b2b_mosi_edges: got %0d bad changes expected 0", cap_mosi_bad); end
  endtask

  task automatic test_backpressure();
    bit ok;
    fork
      begin send_word(8'h12); send_word(8'h34); send_word(8'h56); end
      begin wait_cs_low(10, ok); capture(1100); end
    join
    n_tests++; if (cap_bits !== 32'h123456 || cap_nrise != 24) begin n_fail++; $display("FAIL bp_bits: got %h (%0d rises) expected 123456 (24 rises)", cap_bits, cap_nrise); end
    n_tests++; if (cap_cs_at != 960 || cap_fd != 1) begin n_fail++; $display("FAIL bp_frame: got cs rise %0d, %0d pulses expected 960, 1", cap_cs_at, cap_fd); end
    n_tests++; if ({ready_log[100], ready_log[320], ready_log[420], ready_log[640], ready_log[700]} !== 5'b01011) begin n_fail++; $display("FAIL bp_ready: got %b expected 01011", {ready_log[100], ready_log[320], ready_log[420], ready_log[640], ready_log[700]}); end
  endtask

  task automatic test_reset_mid_word();
    int fd_seen = 0;
    int cs_low  = 0;
    send_word(8'hFF);
    tick();
    send_word(8'h00);
    repeat (144) tick();
    n_tests++; if ({SPI_clk, SPI_mosi} !== 2'b11) begin n_fail++; $display("FAIL rst_pre_state: got clk,mosi=%b expected 11", {SPI_clk, SPI_mosi}); end
    reset = 1'b1;
    #1;
    n_tests++; if ({SPI_clk, SPI_cs_n, SPI_mosi, tx_ready, frame_done} !== 5'b01010) begin n_fail++; $display("FAIL rst_async: got clk,cs_n,mosi,ready,done=%b expected 01010", {SPI_clk, SPI_cs_n, SPI_mosi, tx_ready, frame_done}); end
    repeat (2) begin tick(); if (frame_done) fd_seen++; end
    reset = 1'b0;
    repeat (20) begin tick(); if (frame_done) fd_seen++; if (!SPI_cs_n) cs_low++; end
    n_tests++; if (fd_seen != 0) begin n_fail++; $display("FAIL rst_no_done: got %0d pulses expected 0", fd_seen); end
    n_tests++; if (cs_low != 0 || tx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_hold_dropped: got %0d cs-low cycles, ready %b expected 0, 1", cs_low, tx_ready); end
    send_word(8'h5A);
    tick();
    n_tests++; if ({SPI_cs_n, SPI_mosi} !== 2'b00) begin n_fail++; $display("FAIL rst_next_start: got cs_n,mosi=%b expected 00", {SPI_cs_n, SPI_mosi}); end
    capture(400);
    n_tests++; if (cap_bits !== 32'h5A || cap_cs_at != 320 || cap_fd != 1) begin n_fail++; $display("FAIL rst_next_word: got %h, cs rise %0d, %0d pulses expected 5a, 320, 1", cap_bits, cap_cs_at, cap_fd); end
  endtask

`ifdef SPI_TX_CAL_PREAMBLE_EN
  task automatic test_preamble();
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    n_tests++; if ({cal_busy, SPI_cs_n, SPI_mosi, SPI_clk} !== 4'b1010) begin n_fail++; $display("FAIL pre_start: got busy,cs_n,mosi,clk=%b expected 1010", {cal_busy, SPI_cs_n, SPI_mosi, SPI_clk}); end
    capture(300);
    n_tests++; if (cap_bits !== 32'hA || cap_nrise != PB) begin n_fail++; $display("FAIL pre_pattern: got %h (%0d rises) expected a (4 rises)", cap_bits, cap_nrise); end
    n_tests++; if (cap_busy != 160) begin n_fail++; $display("FAIL pre_busy_len: got %0d expected 160", cap_busy); end
    n_tests++; if (cap_cs_at != 160 || cap_fd != 1) begin n_fail++; $display("FAIL pre_end: got cs rise %0d, %0d pulses expected 160, 1", cap_cs_at, cap_fd); end
  endtask

  task automatic test_cal_in_shift();
    int bad = 0;
    send_word(8'h96);
    tick();
    fork
      begin repeat (50) tick(); cal_start = 1'b1; tick(); cal_start = 1'b0; end
      begin capture(400); end
    join
    n_tests++; if (cap_bits !== 32'h96 || cap_cs_at != 320 || cap_busy != 0) begin n_fail++; $display("FAIL cal_in_shift: got %h, cs rise %0d, busy %0d expected 96, 320, 0", cap_bits, cap_cs_at, cap_busy); end
    repeat (50) begin tick(); if (!SPI_cs_n || cal_busy) bad++; end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL cal_not_queued: got %0d active cycles expected 0", bad); end
  endtask

  task automatic test_cal_with_word();
    cal_start = 1'b1;
    send_word(8'h81);
    cal_start = 1'b0;
    capture(600);
    n_tests++; if (cap_bits !== 32'hA81 || cap_nrise != 12) begin n_fail++; $display("FAIL cal_word_bits: got %h (%0d rises) expected a81 (12 rises)", cap_bits, cap_nrise); end
    n_tests++; if (cap_cs_at != 480 || cap_busy != 160 || cap_fd != 1) begin n_fail++; $display("FAIL cal_word_frame: got cs rise %0d, busy %0d, %0d pulses expected 480, 160, 1", cap_cs_at, cap_busy, cap_fd); end
    n_tests++; if (bad_spacing() != 0 || cap_mosi_bad != 0) begin n_fail++; $display("FAIL cal_word_timing: got %0d bad gaps, %0d bad changes expected 0, 0", bad_spacing(), cap_mosi_bad); end
  endtask
`else
  task automatic test_macro_off();
    cal_start = 1'b1;
    send_word(8'h81);
    cal_start = 1'b0;
    n_tests++; if (cal_busy !== 1'b0) begin n_fail++; $display("FAIL off_busy_E: got %b expected 0", cal_busy); end
    tick();
    n_tests++; if ({SPI_cs_n, SPI_mosi, cal_busy} !== 3'b010) begin n_fail++; $display("FAIL off_start: got cs_n,mosi,busy=%b expected 010", {SPI_cs_n, SPI_mosi, cal_busy}); end
    capture(400);
    n_tests++; if (cap_bits !== 32'h81 || cap_cs_at != 320 || cap_busy != 0) begin n_fail++; $display("FAIL off_word: got %h, cs rise %0d, busy %0d expected 81, 320, 0", cap_bits, cap_cs_at, cap_busy); end
  endtask
`endif

  initial begin
    reset = 1'b1; tx_data = '0; tx_valid = 1'b0; cal_start = 1'b0;
    test_reset();
    test_single_word();
    repeat (5) tick();
    test_back_to_back();
    repeat (5) tick();
    test_backpressure();
    repeat (5) tick();
    test_reset_mid_word();
    repeat (5) tick();
`ifdef SPI_TX_CAL_PREAMBLE_EN
    test_preamble();
    repeat (5) tick();
    test_cal_in_shift();
    repeat (5) tick();
    test_cal_with_word();
`else
    test_macro_off();
`endif
    repeat (5) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
